grain_flex_config_loader: RTL and testbench

On-chip bitstream loader for the GrainFlex fabric's serial programming interface. Accepts the configuration bitstream as a byte stream over a valid/ready handshake, then drives the fabric's programming pins. Those pins are prog reset, enable, clock and data-in. The loader generates the prog clock itself from the system clock and captures the fabric's data-out as a readback byte stream for verification. It sits between the top-level pin/host logic and the fabric's programming port.

---
 rtl/grain_flex_prog_pkg.sv | 18 +
 rtl/grain_flex_prog_shifter.sv | 63 ++++++
 rtl/grain_flex_config_loader.sv | 143 ++++++++++++++
 tb/tb_grain_flex_config_loader.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grain_flex_prog_pkg.sv
// GrainFlex programming loader: shared state encoding
// and default parameter values.
package grain_flex_prog_pkg;

   typedef logic [2:0] state_t;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_RESET  = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_LO     = 3'd3;
   localparam logic [2:0] S_HI     = 3'd4;
   localparam logic [2:0] S_FINISH = 3'd5;

   localparam int DEF_BITSTREAM_LEN = 256;
   localparam int DEF_CLK_DIV       = 2;
   localparam int DEF_RST_CYCLES    = 4;

endpackage

// File: rtl/grain_flex_prog_shifter.sv
// Byte PISO driving prog_din plus readback SIPO
// that assembles prog_dout samples into bytes.
module grain_flex_prog_shifter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       load,
   input  logic [7:0] load_data,
   input  logic       sample,
   input  logic       sample_bit,
   input  logic       advance,
   input  logic       flush,
   output logic       cur_bit,
   output logic       last_bit,
   output logic       rb_valid,
   output logic [7:0] rb_data
);

   logic [7:0] piso;
   logic [7:0] sipo;
   logic [2:0] idx;

   assign cur_bit  = piso[7];
   assign last_bit = (idx == 3'd7);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         piso     <= '0;
         sipo     <= '0;
         idx      <= '0;
         rb_valid <= 1'b0;
         rb_data  <= '0;
      end else begin
         rb_valid <= 1'b0;
         if (clr) begin
            idx  <= '0;
            sipo <= '0;
         end else begin
            if (load) begin
               piso <= load_data;
               idx  <= '0;
            end
            if (sample) begin
               sipo <= {sipo[6:0], sample_bit};
               if (idx == 3'd7) begin
                  rb_valid <= 1'b1;
                  rb_data  <= {sipo[6:0], sample_bit};
               end
            end
            // partial last byte: idx+1 valid bits, left-aligned
            if (flush) begin
               rb_valid <= 1'b1;
               rb_data  <= sipo << (3'd7 - idx);
            end
            if (advance) begin
               piso <= {piso[6:0], 1'b0};
               idx  <= idx + 3'd1;
            end
         end
      end
   end

endmodule

// File: rtl/grain_flex_config_loader.sv
// GrainFlex serial bitstream loader: byte stream in,
// prog pins out, prog_dout readback as bytes.
module grain_flex_config_loader
   import grain_flex_prog_pkg::*;
#(
   parameter int BITSTREAM_LEN = DEF_BITSTREAM_LEN,
   parameter int CLK_DIV       = DEF_CLK_DIV,
   parameter int RST_CYCLES    = DEF_RST_CYCLES
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       byte_ready,
   output logic       rb_valid,
   output logic [7:0] rb_data,
   output logic       busy,
   output logic       done,
   output logic       aborted,
   output logic       prog_clk,
   output logic       prog_rst,
   output logic       prog_en,
   output logic       prog_din,
   input  logic       prog_dout
);

   localparam int PMAX = (CLK_DIV > RST_CYCLES) ? CLK_DIV : RST_CYCLES;
   localparam int PW   = $clog2(PMAX + 1);
   localparam int BW   = $clog2(BITSTREAM_LEN + 1);

   localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] RST_LAST = PW'(RST_CYCLES - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(BITSTREAM_LEN - 1);

   state_t        state;
   logic [PW-1:0] phase;
   logic [BW-1:0] bit_cnt;
   logic          aborted_q;

   logic kill, ph_end, final_bit;
   logic load, sample, advance, flush, clr;
   logic cur_bit, last_bit;

   assign busy      = (state != S_IDLE);
   assign kill      = busy && abort;
   assign ph_end    = (phase == PH_LAST);
   assign final_bit = (bit_cnt == BIT_LAST);

   assign byte_ready = (state == S_WAIT) && !abort;
   assign load       = byte_ready && byte_valid;
   assign sample     = (state == S_LO) && ph_end && !abort;
   assign advance    = (state == S_HI) && ph_end && !abort;
   assign flush      = advance && final_bit && !last_bit;
   assign clr        = kill || ((state == S_IDLE) && start);

   // WAIT with bits already sent is a host stall, not the pre-load wait
   assign prog_en  = (state == S_LO) || (state == S_HI) ||
                     ((state == S_WAIT) && (bit_cnt != '0));
   assign prog_clk = (state == S_HI);
   assign prog_rst = (state == S_RESET);
   assign prog_din = ((state == S_LO) || (state == S_HI)) && cur_bit;
   assign done     = (state == S_FINISH);
   assign aborted  = aborted_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         phase     <= '0;
         bit_cnt   <= '0;
         aborted_q <= 1'b0;
      end else begin
         aborted_q <= kill;
         if (kill) begin
            state <= S_IDLE;
            phase <= '0;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (start) begin
                     state   <= S_RESET;
                     phase   <= '0;
                     bit_cnt <= '0;
                  end
               end
               S_RESET: begin
                  if (phase == RST_LAST) begin
                     state <= S_WAIT;
                     phase <= '0;
                  end else begin
                     phase <= phase + PW'(1);
                  end
               end
               S_WAIT: begin
                  if (load) begin
                     state <= S_LO;
                     phase <= '0;
                  end
               end
               S_LO: begin
                  if (ph_end) begin
                     state <= S_HI;
                     phase <= '0;
                  end else begin
                     phase <= phase + PW'(1);
                  end
               end
               S_HI: begin
                  if (ph_end) begin
                     phase   <= '0;
                     bit_cnt <= bit_cnt + BW'(1);
                     if (final_bit)     state <= S_FINISH;
                     else if (last_bit) state <= S_WAIT;
                     else               state <= S_LO;
                  end else begin
                     phase <= phase + PW'(1);
                  end
               end
               S_FINISH: state <= S_IDLE;
               default:  state <= S_IDLE;
            endcase
         end
      end
   end

   grain_flex_prog_shifter u_shifter (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .load       (load),
      .load_data  (byte_data),
      .sample     (sample),
      .sample_bit (prog_dout),
      .advance    (advance),
      .flush      (flush),
      .cur_bit    (cur_bit),
      .last_bit   (last_bit),
      .rb_valid   (rb_valid),
      .rb_data    (rb_data)
   );

endmodule

// File: tb/tb_grain_flex_config_loader.sv
// Bench for grain_flex_config_loader: 16-bit and 12-bit
// fabric chain models, vector table plus corner sequences.
module tb_grain_flex_config_loader;

   logic clk = 1'b0;
   logic rst_n, start, start2, abort, byte_valid;
   logic [7:0] byte_data;

   logic       byte_ready, rb_valid, busy, done, aborted;
   logic [7:0] rb_data;
   logic       prog_clk, prog_rst, prog_en, prog_din, prog_dout;

   logic       byte_ready2, rb_valid2, busy2, done2, aborted2;
   logic [7:0] rb_data2;
   logic       prog_clk2, prog_rst2, prog_en2, prog_din2, prog_dout2;

   int chks = 0;
   int errs = 0;

   always #5 clk = ~clk;

   grain_flex_config_loader #(
      .BITSTREAM_LEN (16), .CLK_DIV (2), .RST_CYCLES (4)
   ) dut (
      .clk (clk), .rst_n (rst_n), .start (start), .abort (abort),
      .byte_valid (byte_valid), .byte_data (byte_data),
      .byte_ready (byte_ready), .rb_valid (rb_valid), .rb_data (rb_data),
      .busy (busy), .done (done), .aborted (aborted),
      .prog_clk (prog_clk), .prog_rst (prog_rst), .prog_en (prog_en),
      .prog_din (prog_din), .prog_dout (prog_dout)
   );

   grain_flex_config_loader #(
      .BITSTREAM_LEN (12), .CLK_DIV (2), .RST_CYCLES (4)
   ) dut2 (
      .clk (clk), .rst_n (rst_n), .start (start2), .abort (abort),
      .byte_valid (byte_valid), .byte_data (byte_data),
      .byte_ready (byte_ready2), .rb_valid (rb_valid2), .rb_data (rb_data2),
      .busy (busy2), .done (done2), .aborted (aborted2),
      .prog_clk (prog_clk2), .prog_rst (prog_rst2), .prog_en (prog_en2),
      .prog_din (prog_din2), .prog_dout (prog_dout2)
   );

   // fabric chain models
   logic        pre_ld = 1'b0;
   logic [15:0] pre_val = '0;
   logic [15:0] chain;
   logic [11:0] chain2;
   logic [63:0] din_hist = '0;
   logic [63:0] din2_hist = '0;
   int din_n = 0;
   int din2_n = 0;

   assign prog_dout  = chain[15];
   assign prog_dout2 = chain2[11];

   always @(posedge prog_clk or posedge pre_ld)
      if (pre_ld) chain <= pre_val;
      else        chain <= {chain[14:0], prog_din};

   always @(posedge prog_clk2 or posedge pre_ld)
      if (pre_ld) chain2 <= pre_val[11:0];
      else        chain2 <= {chain2[10:0], prog_din2};

   always @(posedge prog_clk) begin
      din_hist <= {din_hist[62:0], prog_din};
      din_n    <= din_n + 1;
   end

   always @(posedge prog_clk2) begin
      din2_hist <= {din2_hist[62:0], prog_din2};
      din2_n    <= din2_n + 1;
   end

   // output event monitor
   logic [7:0] rb_hist [32];
   logic [7:0] rb2_hist [32];
   int rb_n = 0, rb2_n = 0, done_n = 0, done2_n = 0;
   int ab_n = 0, rb2_fin = 0;

   always @(negedge clk) begin
      if (rb_valid) begin
         rb_hist[rb_n % 32] <= rb_data;
         rb_n <= rb_n + 1;
      end
      if (rb_valid2) begin
         rb2_hist[rb2_n % 32] <= rb_data2;
         rb2_n <= rb2_n + 1;
      end
      if (done)    done_n  <= done_n + 1;
      if (done2)   done2_n <= done2_n + 1;
      if (aborted) ab_n    <= ab_n + 1;
      if (rb_valid2 && done2) rb2_fin <= rb2_fin + 1;
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      chks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic preload(input logic [15:0] v);
      pre_val = v;
      pre_ld  = 1'b1;
      #1 pre_ld = 1'b0;
   endtask

   task automatic send_byte(input logic sel, input logic [7:0] b,
                            input string nm);
      int n = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (!(sel ? byte_ready2 : byte_ready) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) chk({nm, " ready timeout"}, 0, 1);
      @(negedge clk);
   endtask

   task automatic wait_done(input logic sel, input string nm);
      int n = 0;
      while (!(sel ? done2 : done) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) chk({nm, " done timeout"}, 0, 1);
   endtask

   typedef struct {
      logic [15:0] pre;
      logic [7:0]  b0;
      logic [7:0]  b1;
      int          gap;
      logic [15:0] exp_din;
      logic [7:0]  exp_rb0;
      logic [7:0]  exp_rb1;
      logic [15:0] exp_chain;
   } vec_t;

   vec_t vecs [3];

   task automatic run_vec(input vec_t v, input string nm);
      int d0, r0, dn0, n;
      logic gap_bad;
      preload(v.pre);
      @(negedge clk);
      #1;
      d0  = din_n;
      r0  = rb_n;
      dn0 = done_n;
      @(negedge clk);
      start = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         chk($sformatf("%s prog_rst c%0d", nm, k), prog_rst, k <= 4);
         chk($sformatf("%s ready c%0d", nm, k), byte_ready, k == 5);
      end
      send_byte(1'b0, v.b0, nm);
      chk({nm, " en after hs"}, {prog_en, prog_clk, prog_din},
          {1'b1, 1'b0, v.b0[7]});
      if (v.gap > 0) begin
         byte_valid = 1'b0;
         n = 0;
         while (!byte_ready && n < 300) begin
            @(negedge clk);
            n++;
         end
         gap_bad = 1'b0;
         repeat (v.gap) begin
            if (prog_clk !== 1'b0 || prog_en !== 1'b1) gap_bad = 1'b1;
            @(negedge clk);
         end
         chk({nm, " gap pins"}, gap_bad, 1'b0);
      end
      send_byte(1'b0, v.b1, nm);
      byte_valid = 1'b0;
      wait_done(1'b0, nm);
      @(negedge clk);
      chk({nm, " busy after"}, busy, 1'b0);
      #1;
      chk({nm, " din count"}, din_n - d0, 16);
      chk({nm, " din bits"}, din_hist[15:0], v.exp_din);
      chk({nm, " rb count"}, rb_n - r0, 2);
      chk({nm, " rb0"}, rb_hist[r0 % 32], v.exp_rb0);
      chk({nm, " rb1"}, rb_hist[(r0 + 1) % 32], v.exp_rb1);
      chk({nm, " done count"}, done_n - dn0, 1);
      chk({nm, " chain"}, chain, v.exp_chain);
   endtask

   initial begin
      int d0, r0, dn0, a0, n;
      vecs[0] = '{16'hFFFF, 8'hA5, 8'h3C, 0,
                  16'hA53C, 8'hFF, 8'hFF, 16'hA53C};
      vecs[1] = '{16'hFFFF, 8'hA5, 8'h3C, 10,
                  16'hA53C, 8'hFF, 8'hFF, 16'hA53C};
      vecs[2] = '{16'h1234, 8'h00, 8'hFF, 3,
                  16'h00FF, 8'h12, 8'h34, 16'h00FF};

      rst_n = 1'b0;
      start = 1'b0;
      start2 = 1'b0;
      abort = 1'b0;
      byte_valid = 1'b0;
      byte_data = '0;
      preload(16'hFFFF);
      repeat (3) @(negedge clk);
      chk("reset outs", {busy, done, aborted, byte_ready, rb_valid, rb_data,
          prog_clk, prog_rst, prog_en, prog_din}, 0);
      chk("reset outs2", {busy2, done2, aborted2, byte_ready2, rb_valid2,
          rb_data2, prog_clk2, prog_rst2, prog_en2, prog_din2}, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 3; i++)
         run_vec(vecs[i], $sformatf("vec%0d", i));

      // abort during bit 5 of byte 0
      preload(16'hFFFF);
      @(negedge clk);
      #1;
      d0 = din_n; r0 = rb_n; dn0 = done_n; a0 = ab_n;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      send_byte(1'b0, 8'hA5, "abort");
      byte_valid = 1'b0;
      n = 0;
      while (din_n - d0 < 5 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("abort reach bit5", din_n - d0, 5);
      repeat (2) @(negedge clk);
      chk("abort in lo", {prog_en, prog_clk}, 2'b10);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort pins", {prog_en, prog_clk, prog_rst, busy}, 0);
      chk("abort pulse", aborted, 1'b1);
      @(negedge clk);
      chk("aborted one cycle", aborted, 1'b0);
      repeat (3) @(negedge clk);
      #1;
      chk("abort no done", done_n - dn0, 0);
      chk("abort no rb", rb_n - r0, 0);
      chk("abort count", ab_n - a0, 1);
      chk("abort bits", din_n - d0, 5);

      run_vec(vecs[0], "post_abort");

      // partial final byte on the 12-bit instance
      preload(16'h0FFF);
      @(negedge clk);
      #1;
      d0 = din2_n; r0 = rb2_n; dn0 = done2_n; a0 = rb2_fin;
      @(negedge clk);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      send_byte(1'b1, 8'hF0, "partial");
      send_byte(1'b1, 8'hA7, "partial");
      byte_valid = 1'b0;
      wait_done(1'b1, "partial");
      @(negedge clk);
      #1;
      chk("partial din count", din2_n - d0, 12);
      chk("partial din bits", din2_hist[11:0], 12'hF0A);
      chk("partial last4", din2_hist[3:0], 4'b1010);
      chk("partial rb count", rb2_n - r0, 2);
      chk("partial rb0", rb2_hist[r0 % 32], 8'hFF);
      chk("partial rb1", rb2_hist[(r0 + 1) % 32], 8'hF0);
      chk("partial rb in finish", rb2_fin - a0, 1);
      chk("partial done", done2_n - dn0, 1);
      chk("partial chain", chain2, 12'hF0A);

      // start while busy, then async reset mid-shift
      preload(16'hFFFF);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      send_byte(1'b0, 8'hFF, "rst");
      byte_valid = 1'b0;
      repeat (5) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("start ignored", {busy, prog_rst, prog_en}, 3'b101);
      n = 0;
      while (!(prog_clk && prog_din) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rst mid hi", {prog_clk, prog_din}, 2'b11);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset outs", {busy, done, aborted, byte_ready, rb_valid,
          rb_data, prog_clk, prog_rst, prog_en, prog_din}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle after reset", {busy, prog_en}, 0);

      $display("Simulation finished: %0d checks, %0d errors", chks, errs);
      $finish;
   end

endmodule
